twiddle_scaler_pipe: RTL and testbench

Parametrised, backpressure-capable twiddle-multiply stage for the NTT datapath. Each accepted beat carries `LANES` coefficients. Lane 0 is scaled by 1 in forward NTT mode or by `N_INV` in inverse NTT mode. Lanes 1..`LANES`-1 are multiplied by per-lane twiddle factors, then reduced modulo `MODULUS` by a pipelined Barrett reducer. The block sits between butterfly stages. It replaces fixed-width, fixed-ROM twiddle stages with a runtime-loadable table, a programmable address stride and a valid/ready handshake.

---
 rtl/twiddle_scaler_pipe.sv | 143 ++++++++++++++
 tb/tb_twiddle_scaler_pipe.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_scaler_pipe.sv
// NTT twiddle-multiply stage: runtime-loadable per-lane twiddle tables,
// strided index, four-stage multiply and Barrett reduction with valid/ready.
module twiddle_scaler_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 8,
  parameter int DEPTH      = 1024,
  parameter int MODULUS    = 12289,
  parameter int N_INV      = 12277
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                valid_in,
  output logic                                ready_in,
  input  logic                                is_inv_ntt,
  input  logic [LANES-1:0][DATA_WIDTH-1:0]    lane_in,
  input  logic                                blk_start,
  input  logic [$clog2(DEPTH)-1:0]            idx_base,
  input  logic [$clog2(DEPTH)-1:0]            idx_stride,
  input  logic                                tw_we,
  input  logic                                tw_inv,
  input  logic [$clog2(LANES)-1:0]            tw_lane,
  input  logic [$clog2(DEPTH)-1:0]            tw_addr,
  input  logic [DATA_WIDTH-1:0]               tw_data,
  output logic                                valid_out,
  input  logic                                ready_out,
  output logic [LANES-1:0][DATA_WIDTH-1:0]    lane_out,
  output logic                                range_err
);

  localparam int DW  = DATA_WIDTH;
  localparam int IW  = $clog2(DEPTH);
  localparam int LW  = $clog2(LANES);
  localparam int PW  = 2 * DW;
  localparam int K   = $clog2(MODULUS);
  localparam int PRW = PW + K + 2;

  localparam logic [PW:0] TWO2K = {{PW{1'b0}}, 1'b1} << (2 * K);
  localparam logic [PW:0] MU    = TWO2K / (PW + 1)'(MODULUS);

  logic          en;
  logic          acc;
  logic          over;
  logic [IW-1:0] idx;

  logic          s1_v;
  logic          s2_v;
  logic          s3_v;
  logic [DW-1:0] s1_a  [LANES];
  logic [DW-1:0] rd    [LANES];
  logic [PW-1:0] s2_p  [LANES];
  logic [PW-1:0] s3_p  [LANES];
  logic [PW-1:0] s3_qh [LANES];
  logic [PW-1:0] qh_c  [LANES];
  logic [DW-1:0] red_c [LANES];

  assign ready_in = !(valid_out && !ready_out);
  assign en       = ready_in;
  assign acc      = valid_in && ready_in;

  // qh never exceeds floor(p/q), so r is non-negative and at most 2q too big
  function automatic logic [DW-1:0] reduce(
    input logic [PW-1:0] p,
    input logic [PW-1:0] qh
  );
    logic [PW-1:0] r;
    r = p - qh * PW'(MODULUS);
    if (r >= PW'(MODULUS)) r = r - PW'(MODULUS);
    if (r >= PW'(MODULUS)) r = r - PW'(MODULUS);
    return r[DW-1:0];
  endfunction

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [DW-1:0] w_q;
    assign rd[j] = w_q;
    if (j == 0) begin : g_unit
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          w_q <= '0;
        end else if (en) begin
          w_q <= is_inv_ntt ? DW'(N_INV) : DW'(1);
        end
      end
    end else begin : g_tab
      logic [DW-1:0] mem [2*DEPTH];
      always_ff @(posedge clk) begin
        if (tw_we && tw_lane == LW'(j)) begin
          mem[{tw_inv, tw_addr}] <= tw_data;
        end
        if (en) begin
          w_q <= mem[{is_inv_ntt, idx}];
        end
      end
    end
  end

  always_comb begin
    over = 1'b0;
    for (int j = 0; j < LANES; j++) begin
      qh_c[j]  = PW'((PRW'(s2_p[j]) * PRW'(MU)) >> (2 * K));
      red_c[j] = reduce(s3_p[j], s3_qh[j]);
      if (lane_in[j] >= DW'(MODULUS)) over = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      range_err <= 1'b0;
      s1_v      <= 1'b0;
      s2_v      <= 1'b0;
      s3_v      <= 1'b0;
      valid_out <= 1'b0;
      lane_out  <= '0;
      for (int j = 0; j < LANES; j++) begin
        s1_a[j]  <= '0;
        s2_p[j]  <= '0;
        s3_p[j]  <= '0;
        s3_qh[j] <= '0;
      end
    end else begin
      if (blk_start) begin
        idx <= idx_base;
      end else if (acc) begin
        idx <= idx + idx_stride;
      end
      if (acc && over) range_err <= 1'b1;
      if (en) begin
        s1_v      <= valid_in;
        s2_v      <= s1_v;
        s3_v      <= s2_v;
        valid_out <= s3_v;
        for (int j = 0; j < LANES; j++) begin
          s1_a[j]     <= lane_in[j];
          s2_p[j]     <= PW'(s1_a[j]) * PW'(rd[j]);
          s3_p[j]     <= s2_p[j];
          s3_qh[j]    <= qh_c[j];
          lane_out[j] <= red_c[j];
        end
      end
    end
  end

endmodule

// File: tb/tb_twiddle_scaler_pipe.sv
// Directed bench for twiddle_scaler_pipe: vector table plus
// latency, backpressure, wrap, range and reset sequences.
module tb_twiddle_scaler_pipe;

  localparam int DW = 32;
  localparam int L  = 8;
  localparam int D  = 1024;
  localparam int Q  = 12289;
  localparam int NI = 12277;

  typedef logic [L-1:0][DW-1:0] lanes_t;
  typedef struct {
    lanes_t a;
    bit     inv;
    int     addr;
    int     e0;
    int     e1;
    int     e4;
    int     e7;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid_in = 1'b0;
  logic         ready_in;
  logic         is_inv_ntt = 1'b0;
  lanes_t       lane_in = '0;
  logic         blk_start = 1'b0;
  logic [9:0]   idx_base = '0;
  logic [9:0]   idx_stride = '0;
  logic         tw_we = 1'b0;
  logic         tw_inv = 1'b0;
  logic [2:0]   tw_lane = '0;
  logic [9:0]   tw_addr = '0;
  logic [31:0]  tw_data = '0;
  logic         valid_out;
  logic         ready_out = 1'b1;
  lanes_t       lane_out;
  logic         range_err;

  always #5 clk = ~clk;

  twiddle_scaler_pipe #(
    .DATA_WIDTH(DW), .LANES(L), .DEPTH(D), .MODULUS(Q), .N_INV(NI)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .ready_in(ready_in),
    .is_inv_ntt(is_inv_ntt), .lane_in(lane_in),
    .blk_start(blk_start), .idx_base(idx_base), .idx_stride(idx_stride),
    .tw_we(tw_we), .tw_inv(tw_inv), .tw_lane(tw_lane),
    .tw_addr(tw_addr), .tw_data(tw_data),
    .valid_out(valid_out), .ready_out(ready_out),
    .lane_out(lane_out), .range_err(range_err)
  );

  int          errors = 0;
  int          checks = 0;
  logic [31:0] fm [L][D];
  logic [31:0] im [L][D];
  lanes_t      got [$];
  lanes_t      expq [$];
  int          hold_err = 0;
  int          stall_seen = 0;
  bit          held = 0;
  lanes_t      held_val;
  vec_t        vt [7];

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // entered at posedge+1 with inputs set; returns at next posedge+1
  task automatic tick(output bit acc);
    #1;
    if (held && (!valid_out || lane_out != held_val)) hold_err++;
    held     = valid_out && !ready_out;
    held_val = lane_out;
    if (!ready_in) stall_seen++;
    if (valid_out && ready_out) got.push_back(lane_out);
    acc = valid_in && ready_in;
    @(posedge clk);
    #1;
  endtask

  function automatic lanes_t mk(int a0, int aj);
    lanes_t r;
    for (int j = 0; j < L; j++) r[j] = (j == 0) ? a0 : aj;
    return r;
  endfunction

  function automatic lanes_t model(lanes_t a, bit inv, int addr);
    lanes_t r;
    longint unsigned w;
    for (int j = 0; j < L; j++) begin
      if (j == 0) w = inv ? NI : 1;
      else        w = inv ? im[j][addr] : fm[j][addr];
      r[j] = 32'((longint'(a[j]) * w) % Q);
    end
    return r;
  endfunction

  task automatic tw_write(bit inv, int lane, int addr, int data);
    bit d;
    tw_we = 1; tw_inv = inv; tw_lane = 3'(lane);
    tw_addr = 10'(addr); tw_data = data;
    tick(d);
    tw_we = 0;
    if (inv) im[lane][addr] = data;
    else     fm[lane][addr] = data;
  endtask

  task automatic drain(int n);
    bit d;
    for (int c = 0; c < 40 && got.size() < n; c++) tick(d);
    check("drain_count", got.size(), n);
  endtask

  task automatic run_one(lanes_t a, bit inv, int addr, output lanes_t r);
    bit d;
    got.delete();
    blk_start = 1; idx_base = 10'(addr); valid_in = 0;
    tick(d);
    blk_start = 0; valid_in = 1; lane_in = a; is_inv_ntt = inv;
    tick(d);
    valid_in = 0;
    drain(1);
    r = (got.size() > 0) ? got.pop_front() : '0;
  endtask

  initial begin
    bit     acc;
    lanes_t r;
    lanes_t a;
    int     beat;
    int     midx;
    bit     pat [4];

    vt[0] = '{mk(2, 2),          0, 0,    2,     14,    56,    98};
    vt[1] = '{mk(1024, 3),       1, 0,    1,     315,   1215,  2115};
    vt[2] = '{mk(12288, 12288),  0, 3,    12288, 12279, 12258, 12237};
    vt[3] = '{mk(0, 0),          1, 5,    0,     0,     0,     0};
    vt[4] = '{mk(5, 12288),      1, 7,    12229, 12177, 11877, 11577};
    vt[5] = '{mk(12288, 12288),  0, 8,    12288, 12274, 1,     12232};
    vt[6] = '{mk(12000, 12000),  0, 1023, 12000, 9555,  3486,  9706};
    pat = '{1, 0, 0, 1};

    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    check("rst_valid_out", valid_out, 0);
    check("rst_lane_out", lane_out, 0);
    check("rst_range_err", range_err, 0);
    check("rst_ready_in", ready_in, 1);

    for (int j = 1; j < L; j++) begin
      for (int i = 0; i < 16; i++) begin
        tw_write(0, j, i, (7 * j + i) % Q);
        tw_write(1, j, i, 100 * j + i + 5);
      end
      for (int i = 1016; i < D; i++) tw_write(0, j, i, 7 * j + i);
    end
    tw_write(0, 4, 8, Q - 1);

    foreach (vt[v]) begin
      run_one(vt[v].a, vt[v].inv, vt[v].addr, r);
      check($sformatf("vec%0d_lane0", v), r[0], vt[v].e0);
      check($sformatf("vec%0d_lane1", v), r[1], vt[v].e1);
      check($sformatf("vec%0d_lane4", v), r[4], vt[v].e4);
      check($sformatf("vec%0d_lane7", v), r[7], vt[v].e7);
    end

    got.delete();
    blk_start = 1; idx_base = 0;
    tick(acc);
    blk_start = 0; idx_stride = 1; valid_in = 1;
    lane_in = mk(2, 2); is_inv_ntt = 0;
    for (int k = 0; k < 8; k++) begin
      tick(acc);
      if (k == 3) valid_in = 0;
      check($sformatf("lat_valid_c%0d", k), valid_out, (k >= 3 && k <= 6));
      if (k >= 3 && k <= 6) begin
        check($sformatf("lat_lane1_c%0d", k), lane_out[1], 2 * (7 + k - 3));
        check($sformatf("lat_lane0_c%0d", k), lane_out[0], 2);
      end
    end

    got.delete(); expq.delete();
    hold_err = 0; stall_seen = 0;
    blk_start = 1; idx_base = 0;
    tick(acc);
    blk_start = 0; midx = 0; beat = 0;
    for (int c = 0; c < 200 && beat < 10; c++) begin
      ready_out = pat[c % 4];
      for (int j = 0; j < L; j++) a[j] = 32'((beat * 37 + j * 101 + 3) % Q);
      valid_in = 1; lane_in = a; is_inv_ntt = beat[0];
      tick(acc);
      if (acc) begin
        expq.push_back(model(a, beat[0], midx));
        midx = (midx + 1) % D;
        beat++;
      end
    end
    valid_in = 0;
    for (int c = 0; c < 100 && got.size() < 10; c++) begin
      ready_out = pat[c % 4];
      tick(acc);
    end
    ready_out = 1;
    check("bp_out_count", got.size(), 10);
    check("bp_exp_count", expq.size(), 10);
    for (int i = 0; i < 10 && i < got.size() && i < expq.size(); i++) begin
      if (got[i] != expq[i]) begin
        errors++;
        $display("FAIL bp_beat%0d: got %h expected %h", i, got[i], expq[i]);
      end
      checks++;
    end
    check("bp_hold_stable_violations", hold_err, 0);
    check("bp_ready_in_dropped", stall_seen > 0, 1);

    for (int run = 0; run < 2; run++) begin
      got.delete();
      blk_start = 1; idx_base = 10'd1020;
      tick(acc);
      blk_start = 0; idx_stride = 3;
      lane_in = mk(1, 1); is_inv_ntt = 0;
      for (int b = 0; b < 4; b++) begin
        valid_in = 1;
        blk_start = (run == 1 && b == 2);
        tick(acc);
      end
      valid_in = 0; blk_start = 0;
      drain(4);
      if (got.size() == 4) begin
        check($sformatf("wrap%0d_b0", run), got[0][1], 1027);
        check($sformatf("wrap%0d_b1", run), got[1][1], 1030);
        check($sformatf("wrap%0d_b2", run), got[2][1], 9);
        check($sformatf("wrap%0d_b3", run), got[3][1], run ? 1027 : 12);
        check($sformatf("wrap%0d_b3_l7", run), got[3][7], run ? 1069 : 54);
      end
    end

    got.delete();
    check("range_err_clear", range_err, 0);
    a = mk(1, 1); a[3] = Q;
    valid_in = 1; lane_in = a; idx_stride = 1;
    tick(acc);
    check("range_err_set", range_err, 1);
    lane_in = mk(1, 1);
    repeat (3) tick(acc);
    valid_in = 0;
    drain(4);
    check("range_err_sticky", range_err, 1);

    got.delete();
    blk_start = 1; idx_base = 0;
    tick(acc);
    blk_start = 0; valid_in = 1; lane_in = mk(3, 3);
    repeat (3) tick(acc);
    valid_in = 0;
    tick(acc);
    check("rst_mid_pre_valid", valid_out, 1);
    #2 rst_n = 0;
    #1;
    check("rst_mid_valid_out", valid_out, 0);
    check("rst_mid_range_err", range_err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    held = 0;
    got.delete();
    repeat (8) tick(acc);
    check("rst_no_stale_out", got.size(), 0);
    valid_in = 1; lane_in = mk(1, 1); is_inv_ntt = 0;
    tick(acc);
    valid_in = 0;
    drain(1);
    if (got.size() > 0) begin
      r = got.pop_front();
      check("rst_tab_lane1", r[1], 7);
      check("rst_tab_lane4", r[4], 28);
      check("rst_tab_lane7", r[7], 49);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
